// File: rtl/cpu_io_pkg.sv
// -----------------------------------------------------------------------------
// cpu_io_pkg
// Shared definitions for the CPU I/O stages: data width of the CPU I/O
// registers, the default UART bit period and the encoding of the UART
// transmitter FSM states.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_io_pkg;

    // Width of the CPU output/input registers.
    localparam int DATA_W = 8;

    // Default number of clock cycles per UART bit.
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    // UART transmitter FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with show-ahead read data. Push and pop in the same cycle
// are both honoured; a push into a full FIFO is accepted only when a pop
// happens in the same cycle. Storage is not reset; reset flushes the FIFO by
// clearing the pointers and the count.
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - synchronous, active-high reset
//   push_i   - write wdata_i this cycle
//   wdata_i  - write data
//   pop_i    - remove the head entry this cycle
//   rdata_o  - head entry (valid while empty_o is low)
//   full_o   - FIFO holds DEPTH entries
//   empty_o  - FIFO holds no entries
//   count_o  - number of entries held
// DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok_s = push_i && (!full_o || pop_i);
    assign pop_ok_s  = pop_i && !empty_o;

    // Next pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write port.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/outreg_uart_tx.sv
// -----------------------------------------------------------------------------
// outreg_uart_tx
// Watches the CPU output register, queues every change of its value and sends
// each queued byte as a UART 8N1 frame, LSB first. There is no back-pressure:
// a change arriving while the FIFO is full (and no pop happens that cycle) is
// dropped and recorded in the sticky overflow flag.
// Ports:
//   clk_in         - clock, rising edge
//   reset          - synchronous, active-high reset
//   outregister_in - CPU output register value, sampled every cycle
//   tx             - UART line, idles high (registered)
//   busy           - FIFO non-empty or a frame in progress (registered)
//   overflow       - sticky flag: a change was dropped (registered)
//   fifo_count     - number of queued bytes (FIFO count register)
// -----------------------------------------------------------------------------
module outreg_uart_tx
    import cpu_io_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             outregister_in,
    output logic                          tx,
    output logic                          busy,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [BW-1:0]     baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] shadow_q;
    logic              tx_q, tx_d;
    logic              busy_q, busy_d;
    logic              overflow_q, overflow_d;

    logic              change_s;
    logic              drop_s;
    logic              push_s;
    logic              pop_s;
    logic              bit_end_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [DATA_W-1:0] fifo_rdata_s;
    logic [CW-1:0]     fifo_count_s;
    logic [CW-1:0]     count_next_s;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_i   (reset),
        .push_i  (push_s),
        .wdata_i (outregister_in),
        .pop_i   (pop_s),
        .rdata_o (fifo_rdata_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s),
        .count_o (fifo_count_s)
    );

    assign change_s  = (outregister_in != shadow_q);
    // Drop only when full and nothing leaves this cycle.
    assign drop_s    = change_s && fifo_full_s && !pop_s;
    assign push_s    = change_s && !drop_s;
    assign bit_end_s = (baud_q == BAUD_LAST);
    // Occupancy after this edge, so busy agrees with fifo_count in every cycle.
    assign count_next_s = fifo_count_s + CW'(push_s) - CW'(pop_s);

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign overflow   = overflow_q;
    assign fifo_count = fifo_count_s;

    // TX FSM next state, baud counter, bit index, shift register and pop.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        pop_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                baud_d    = '0;
                bit_idx_d = 3'd0;
                if (!fifo_empty_s) begin
                    pop_s   = 1'b1;
                    shift_d = fifo_rdata_s;
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) begin
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    state_d   = ST_DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end_s) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end_s) begin
                    baud_d = '0;
                    // Chain the next frame straight after the stop bit.
                    if (!fifo_empty_s) begin
                        pop_s   = 1'b1;
                        shift_d = fifo_rdata_s;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: begin
                baud_d    = '0;
                bit_idx_d = 3'd0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // Output values derived from the state being entered, so tx follows the FSM without lag.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            ST_IDLE:  tx_d = 1'b1;
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shift_d[0];
            ST_STOP:  tx_d = 1'b1;
            default:  tx_d = 1'b1;
        endcase
        busy_d     = (state_d != ST_IDLE) || (count_next_s != '0);
        overflow_d = overflow_q | drop_s;
    end

    // State, datapath and output registers.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_idx_q  <= 3'd0;
            shift_q    <= '0;
            shadow_q   <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            shadow_q   <= outregister_in;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_outreg_uart_tx.sv
// -----------------------------------------------------------------------------
// tb_outreg_uart_tx
// Self-checking bench for outreg_uart_tx (CLKS_PER_BIT=16, FIFO_DEPTH=4).
// A behavioural model (byte queue plus remaining-frame-time counter) predicts
// tx, busy, overflow and fifo_count every cycle; an independent UART receiver
// decodes the tx line so the transmitted byte order can be compared too.
// -----------------------------------------------------------------------------
module tb_outreg_uart_tx;

    localparam int C     = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * C;

    logic       clk_r = 1'b0;
    logic       rst_r;
    logic [7:0] din_r;
    logic       tx_s;
    logic       busy_s;
    logic       ovf_s;
    logic [2:0] cnt_s;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [7:0] mq[$];
    int         m_rem;
    logic [7:0] m_cur;
    logic [7:0] m_shadow;
    logic       m_ovf;

    // Receiver state
    logic       rx_act;
    int         rx_cnt;
    logic [7:0] rx_byte;
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         max_cnt;

    outreg_uart_tx #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk_in         (clk_r),
        .reset          (rst_r),
        .outregister_in (din_r),
        .tx             (tx_s),
        .busy           (busy_s),
        .overflow       (ovf_s),
        .fifo_count     (cnt_s)
    );

    always #5 clk_r = ~clk_r;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic model_tx();
        int idx;
        if (m_rem == 0) return 1'b1;
        idx = (FRAME - m_rem) / C;
        if (idx == 0) return 1'b0;
        else if (idx <= 8) return m_cur[idx-1];
        else return 1'b1;
    endfunction

    // Advance the model by one rising edge with the inputs applied in that cycle.
    task automatic model_edge(input logic [7:0] val, input logic rst);
        int         sz0;
        logic       popped;
        logic [7:0] pv;
        if (rst) begin
            mq.delete();
            m_rem    = 0;
            m_shadow = 8'h00;
            m_ovf    = 1'b0;
        end else begin
            sz0    = mq.size();
            popped = 1'b0;
            pv     = 8'h00;
            // Idle, or last stop cycle: take the next byte.
            if (sz0 > 0 && m_rem <= 1) begin
                pv     = mq.pop_front();
                popped = 1'b1;
            end
            if (val != m_shadow) begin
                if (sz0 < DEPTH || popped) mq.push_back(val);
                else m_ovf = 1'b1;
                m_shadow = val;
            end
            if (popped) begin
                m_cur = pv;
                m_rem = FRAME;
            end else if (m_rem > 0) begin
                m_rem--;
            end
        end
    endtask

    // Independent UART receiver, sampling mid-bit.
    task automatic rx_step(input logic rst);
        if (rst) begin
            rx_act = 1'b0;
        end else if (!rx_act) begin
            if (tx_s == 1'b0) begin
                rx_act = 1'b1;
                rx_cnt = 0;
            end
        end else begin
            rx_cnt++;
            if ((rx_cnt % C) == C/2 && (rx_cnt / C) >= 1 && (rx_cnt / C) <= 8)
                rx_byte[rx_cnt / C - 1] = tx_s;
            if (rx_cnt == 9*C + C/2) begin
                chk_eq("stop_bit", 32'(tx_s), 32'd1);
                rx_q.push_back(rx_byte);
                rx_act = 1'b0;
            end
        end
    endtask

    // One clock cycle: drive, clock, model, then compare on the falling edge.
    task automatic cycle(input logic [7:0] val, input logic rst);
        din_r = val;
        rst_r = rst;
        @(posedge clk_r);
        model_edge(val, rst);
        @(negedge clk_r);
        chk_eq("tx",         32'(tx_s),   32'(model_tx()));
        chk_eq("busy",       32'(busy_s), 32'((m_rem != 0) || (mq.size() != 0)));
        chk_eq("overflow",   32'(ovf_s),  32'(m_ovf));
        chk_eq("fifo_count", 32'(cnt_s),  32'(mq.size()));
        if (int'(cnt_s) > max_cnt) max_cnt = int'(cnt_s);
        rx_step(rst);
    endtask

    task automatic run(input int n, input logic [7:0] val);
        for (int i = 0; i < n; i++) cycle(val, 1'b0);
    endtask

    task automatic do_reset(input int n, input logic [7:0] val);
        for (int i = 0; i < n; i++) cycle(val, 1'b1);
        rx_q.delete();
        max_cnt = 0;
    endtask

    task automatic chk_rx(input string tag);
        chk_eq({tag, "_nbytes"}, 32'(rx_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            chk_eq({tag, "_byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
    endtask

    initial begin
        logic [7:0] v;
        int         hold;
        rst_r    = 1'b1;
        din_r    = 8'h00;
        mq.delete();
        m_rem    = 0;
        m_cur    = 8'h00;
        m_shadow = 8'h00;
        m_ovf    = 1'b0;
        rx_act   = 1'b0;
        rx_cnt   = 0;
        rx_byte  = 8'h00;
        max_cnt  = 0;

        // Reset state
        do_reset(2, 8'h00);
        chk_eq("rst_tx",    32'(tx_s),   32'd1);
        chk_eq("rst_busy",  32'(busy_s), 32'd0);
        chk_eq("rst_ovf",   32'(ovf_s),  32'd0);
        chk_eq("rst_count", 32'(cnt_s),  32'd0);

        // 1: single byte 0x04, two-cycle latency to start bit
        cycle(8'h04, 1'b0);
        chk_eq("s1_tx_capture_cycle", 32'(tx_s),  32'd1);
        chk_eq("s1_count_queued",     32'(cnt_s), 32'd1);
        cycle(8'h04, 1'b0);
        chk_eq("s1_start_bit",        32'(tx_s),  32'd0);
        chk_eq("s1_count_popped",     32'(cnt_s), 32'd0);
        run(FRAME + 20, 8'h04);
        exp_q = {8'h04};
        chk_rx("s1");
        chk_eq("s1_busy_end",  32'(busy_s), 32'd0);
        chk_eq("s1_count_end", 32'(cnt_s),  32'd0);

        // 2: constant zero, no frames
        do_reset(2, 8'h00);
        run(500, 8'h00);
        exp_q.delete();
        chk_rx("s2");
        chk_eq("s2_busy", 32'(busy_s), 32'd0);

        // 3: five back-to-back changes, FIFO fills to 4 without overflow
        do_reset(2, 8'h00);
        cycle(8'h11, 1'b0);
        cycle(8'h22, 1'b0);
        cycle(8'h33, 1'b0);
        cycle(8'h44, 1'b0);
        cycle(8'h55, 1'b0);
        run(5 * FRAME + 20, 8'h55);
        chk_eq("s3_peak_count", 32'(max_cnt), 32'd4);
        chk_eq("s3_overflow",   32'(ovf_s),   32'd0);
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        chk_rx("s3");

        // 4: a sixth change overflows and is dropped
        do_reset(2, 8'h00);
        cycle(8'h11, 1'b0);
        cycle(8'h22, 1'b0);
        cycle(8'h33, 1'b0);
        cycle(8'h44, 1'b0);
        cycle(8'h55, 1'b0);
        chk_eq("s4_ovf_before", 32'(ovf_s), 32'd0);
        cycle(8'h66, 1'b0);
        chk_eq("s4_ovf_after",  32'(ovf_s), 32'd1);
        run(5 * FRAME + 20, 8'h66);
        chk_eq("s4_ovf_sticky", 32'(ovf_s), 32'd1);
        exp_q = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        chk_rx("s4");

        // 5: 04 -> 00 -> 04, each held 200 cycles
        do_reset(2, 8'h00);
        run(200, 8'h04);
        run(200, 8'h00);
        run(200, 8'h04);
        exp_q = {8'h04, 8'h00, 8'h04};
        chk_rx("s5");

        // 6: reset during data bit 3 of a 0xA5 frame
        do_reset(2, 8'h00);
        cycle(8'hA5, 1'b0);
        cycle(8'hA5, 1'b0);
        chk_eq("s6_start_bit", 32'(tx_s), 32'd0);
        run(4 * C + 3, 8'hA5);
        for (int i = 0; i < 3; i++) begin
            cycle(8'hA5, 1'b1);
            chk_eq("s6_rst_tx",    32'(tx_s),  32'd1);
            chk_eq("s6_rst_count", 32'(cnt_s), 32'd0);
        end
        rx_q.delete();
        cycle(8'hA5, 1'b0);
        chk_eq("s6_requeue",     32'(cnt_s), 32'd1);
        chk_eq("s6_tx_capture",  32'(tx_s),  32'd1);
        cycle(8'hA5, 1'b0);
        chk_eq("s6_restart_bit", 32'(tx_s),  32'd0);
        run(FRAME + 20, 8'hA5);
        exp_q = {8'hA5};
        chk_rx("s6");

        // Randomised traffic: bursts, long holds and occasional resets
        do_reset(2, 8'h00);
        for (int s = 0; s < 40; s++) begin
            v = 8'($urandom);
            if ($urandom_range(9, 0) == 0) begin
                for (int i = 0; i < int'($urandom_range(3, 1)); i++) cycle(v, 1'b1);
            end else begin
                if ($urandom_range(1, 0) == 0) hold = int'($urandom_range(3, 1));
                else hold = int'($urandom_range(400, 100));
                run(hold, v);
            end
        end
        run(6 * FRAME, v);
        chk_eq("rand_drained_busy", 32'(busy_s), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
